// File: rtl/btn_intr_pkg.sv
// Shared types and defaults for the button interrupt controller.
// The FSM state encoding lives here so that benches and wrappers can decode it.
package btn_intr_pkg;

    localparam int unsigned N_SRC_DEF    = 4;
    localparam int unsigned TICK_MAX_DEF = 999999;
    localparam int unsigned N_SRC_MIN    = 2;
    localparam int unsigned N_SRC_MAX    = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: scans req starting one past the last granted index,
// wrapping at N, and returns the first set position.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);

    localparam int unsigned IdW = $clog2(N);

    logic [IdW-1:0] cand;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        // k runs to N so the last granted source is considered last, not skipped.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdW'((32'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/btn_intr_ctrl.sv
// Button event interrupt controller: rising-edge capture into pending flags,
// round-robin service via a REQ/ack handshake. Optional debounce tick under TICK_GEN_EN.
module btn_intr_ctrl
    import btn_intr_pkg::*;
#(
    parameter int unsigned N_SRC    = N_SRC_DEF,
    parameter int unsigned TICK_MAX = TICK_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         db_in,
    input  logic                     intr_ack,
    output logic                     interrupt,
    output logic [$clog2(N_SRC)-1:0] evt_id,
    output logic [N_SRC-1:0]         pend,
    output logic [N_SRC-1:0]         overrun
`ifdef TICK_GEN_EN
    ,
    output logic                     m_tick
`endif
);

    localparam int unsigned IdW = $clog2(N_SRC);

    if (N_SRC < N_SRC_MIN || N_SRC > N_SRC_MAX || TICK_MAX == 0) begin : g_param_check
        $error("btn_intr_ctrl: N_SRC must be 2..8 and TICK_MAX nonzero");
    end

    state_e         state_q, state_d;
    logic [N_SRC-1:0] db_prev_q, db_prev_d;
    logic             first_q, first_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [IdW-1:0]   last_grant_q, last_grant_d;
    logic [IdW-1:0]   evt_id_q, evt_id_d;
    logic             interrupt_q, interrupt_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] grant_clr;
    logic [IdW-1:0]   rr_grant;
    logic             rr_valid;

    rr_pick #(
        .N (N_SRC)
    ) u_rr_pick (
        .req   (pend_q),
        .last  (last_grant_q),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    // Buttons already held at reset release must not look like fresh presses.
    always_comb begin
        db_prev_d = db_in;
        first_d   = 1'b0;
        rise      = first_q ? '0 : (db_in & ~db_prev_q);
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        interrupt_d  = interrupt_q;
        last_grant_d = last_grant_q;
        grant_clr    = '0;
        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    grant_clr[rr_grant] = 1'b1;
                    evt_id_d            = rr_grant;
                    interrupt_d         = 1'b1;
                    state_d             = REQ;
                end
            end
            REQ: begin
                if (intr_ack) begin
                    interrupt_d  = 1'b0;
                    last_grant_d = evt_id_q;
                    state_d      = WAIT_REL;
                end
            end
            WAIT_REL: begin
                interrupt_d = 1'b0;
                if (!intr_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                interrupt_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // A new rise on the same edge as its grant-clear wins, so no event is lost.
    always_comb begin
        pend_d    = (pend_q & ~grant_clr) | rise;
        overrun_d = overrun_q | (rise & pend_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            db_prev_q    <= '0;
            first_q      <= 1'b1;
            pend_q       <= '0;
            overrun_q    <= '0;
            last_grant_q <= IdW'(N_SRC - 1);
            evt_id_q     <= '0;
            interrupt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_prev_q    <= db_prev_d;
            first_q      <= first_d;
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            last_grant_q <= last_grant_d;
            evt_id_q     <= evt_id_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign interrupt = interrupt_q;
    assign evt_id    = evt_id_q;
    assign pend      = pend_q;
    assign overrun   = overrun_q;

`ifdef TICK_GEN_EN
    localparam int unsigned CntW = $clog2(TICK_MAX + 1);

    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick_term;

    always_comb begin
        tick_term  = (tick_cnt_q == CntW'(TICK_MAX));
        tick_cnt_d = tick_term ? '0 : tick_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign m_tick = tick_term;
`endif

endmodule

// File: tb/tb_btn_intr_ctrl.sv
// Directed bench for btn_intr_ctrl (N_SRC=4, TICK_MAX=9); tick checks only when
// TICK_GEN_EN is defined.
module tb_btn_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] db_in;
    logic       intr_ack;
    logic       interrupt;
    logic [1:0] evt_id;
    logic [3:0] pend;
    logic [3:0] overrun;
`ifdef TICK_GEN_EN
    logic       m_tick;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_intr_ctrl #(
        .N_SRC    (4),
        .TICK_MAX (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .db_in     (db_in),
        .intr_ack  (intr_ack),
        .interrupt (interrupt),
        .evt_id    (evt_id),
        .pend      (pend),
        .overrun   (overrun)
`ifdef TICK_GEN_EN
        ,
        .m_tick    (m_tick)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_intr(input string tag);
        int n = 0;
        while (interrupt !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, 32'(interrupt), 32'd1);
    endtask

    task automatic ack_it(input string tag);
        intr_ack = 1'b1;
        step();
        chk({tag, "_drop"}, 32'(interrupt), 32'd0);
        intr_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        db_in    = 4'b0010;
        intr_ack = 1'b0;
        #2;
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_evt_id",    32'(evt_id),    32'd0);
        chk("rst_pend",      32'(pend),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
`ifdef TICK_GEN_EN
        chk("rst_m_tick",    32'(m_tick),    32'd0);
`endif
        step();
        step();
        rst = 1'b0;

        // Button already held through reset release: nothing happens.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_pend", 32'(pend),      32'd0);
            chk("held_intr", 32'(interrupt), 32'd0);
        end

        // Single press on source 2.
        db_in = 4'b0110;
        step();
        chk("p2_pend_t",   32'(pend),      32'h4);
        chk("p2_intr_t",   32'(interrupt), 32'd0);
        step();
        chk("p2_intr_t1",  32'(interrupt), 32'd1);
        chk("p2_evt_t1",   32'(evt_id),    32'd2);
        chk("p2_pend_t1",  32'(pend),      32'd0);
        repeat (3) step();
        chk("p2_hold",     32'(interrupt), 32'd1);
        chk("p2_hold_evt", 32'(evt_id),    32'd2);
        ack_it("p2");
        chk("p2_pend_end", 32'(pend),      32'd0);
        step();
        chk("p2_wr_intr",  32'(interrupt), 32'd0);
        chk("p2_evt_kept", 32'(evt_id),    32'd2);
        db_in = 4'b0000;
        step();

        // Fresh reset so round-robin restarts with last_grant = 3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        db_in = 4'b1111;
        step();
        chk("all_pend", 32'(pend), 32'hf);
        step();
        chk("all_pend_after_grant", 32'(pend), 32'he);
        for (int i = 0; i < 4; i++) begin
            wait_intr("rr1");
            chk($sformatf("rr1_evt%0d", i), 32'(evt_id), 32'(i));
            ack_it("rr1");
        end
        db_in = 4'b0000;
        step();
        step();
        db_in = 4'b1111;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            wait_intr("rr2");
            chk($sformatf("rr2_evt%0d", i), 32'(evt_id), 32'(i));
            ack_it("rr2");
        end
        db_in = 4'b0000;
        step();
        step();
        chk("rr2_idle_pend", 32'(pend), 32'd0);

        // Source 1 pressed twice while source 0 is being serviced.
        db_in = 4'b0001;
        step();
        wait_intr("ov0");
        chk("ov_evt0", 32'(evt_id), 32'd0);
        db_in = 4'b0011;
        step();
        db_in = 4'b0001;
        step();
        db_in = 4'b0011;
        step();
        chk("ov_pend",    32'(pend),      32'h2);
        chk("ov_flag",    32'(overrun),   32'h2);
        chk("ov_in_req",  32'(interrupt), 32'd1);
        ack_it("ov0");
        wait_intr("ov1");
        chk("ov_evt1",    32'(evt_id),  32'd1);
        chk("ov_sticky1", 32'(overrun), 32'h2);
        ack_it("ov1");
        step();
        chk("ov_sticky2", 32'(overrun), 32'h2);
        chk("ov_pend0",   32'(pend),    32'd0);
        db_in = 4'b0000;
        step();

        // Reset in the middle of a request with events pending.
        db_in = 4'b0001;
        step();
        wait_intr("ar");
        chk("ar_evt", 32'(evt_id), 32'd0);
        db_in = 4'b1011;
        step();
        chk("ar_pend_pre", 32'(pend),      32'ha);
        chk("ar_intr_pre", 32'(interrupt), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_intr",    32'(interrupt), 32'd0);
        chk("ar_pend",    32'(pend),      32'd0);
        chk("ar_overrun", 32'(overrun),   32'd0);
        chk("ar_evt_rst", 32'(evt_id),    32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ar_post_intr", 32'(interrupt), 32'd0);
            chk("ar_post_pend", 32'(pend),      32'd0);
        end

`ifdef TICK_GEN_EN
        rst = 1'b1;
        #1;
        chk("tick_rst", 32'(m_tick), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk($sformatf("tick_k%0d", k), 32'(m_tick), (k % 10 == 9) ? 32'd1 : 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
